elevator_dispatch: RTL

ELEVATOR_DISPATCH -- requirements
Module: elevator_dispatch

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_request_queue.sv | 23 ++
 rtl/elevator_dispatch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator dispatcher.
// State encoding and direction codes are fixed here so every file agrees on them.
package elevator_pkg;

  localparam int FLOORS_DEF     = 6;
  localparam int DOOR_TICKS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR_OPEN = 2'b11
  } state_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/elevator_request_queue.sv
// One bank of pending-request bits: presses set bits, serving a floor clears its bit.
// A clear only ever targets the floor being served, so clear-over-set leaves other sets intact.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] set_bits,
  input  logic [FLOORS-1:0] clr_bits,
  output logic [FLOORS-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= (q | set_bits) & ~clr_bits;
    end
  end

endmodule

// File: rtl/elevator_dispatch.sv
// Single-car elevator dispatcher: collects hall/car requests and sweeps the car
// floor by floor on each slow tick, opening the door where a request is served.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int FLOORS     = FLOORS_DEF,
  parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [FLOORS-1:0] outsideUp,
  input  logic [FLOORS-1:0] outsideDown,
  input  logic [FLOORS-1:0] insideFloor,
  output logic [2:0]        currentFloor,
  output logic [1:0]        direction,
  output logic              doorOpen,
  output logic [FLOORS-1:0] queueUp,
  output logic [FLOORS-1:0] queueDown,
  output logic [FLOORS-1:0] queueinside
);

  localparam int         DW  = (DOOR_TICKS > 2) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [2:0] TOP = 3'(FLOORS - 1);

  state_t        state, state_next;
  logic [2:0]    cur_floor, floor_next;
  logic [1:0]    dir, dir_next;
  logic [DW-1:0] dwell, dwell_next;

  function automatic logic [FLOORS-1:0] onehot(input logic [2:0] f);
    logic [FLOORS-1:0] oh;
    for (int i = 0; i < FLOORS; i++) oh[i] = (i == int'(f));
    return oh;
  endfunction

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (i > int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (i < int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  logic [FLOORS-1:0] all_req, here_mask, up_mask, dn_mask, top_mask, bottom_mask;
  logic [FLOORS-1:0] block_up, block_dn, block_in;
  logic [FLOORS-1:0] set_up, set_dn, set_in, clr_up, clr_dn, clr_in;
  logic [2:0]        next_up, next_dn;
  logic              pend_above, pend_below, pend_here, go_up, restart;
  logic              above_next, below_next, rev_up, rev_dn, stop_up, stop_dn;

  assign all_req     = queueUp | queueDown | queueinside;
  assign here_mask   = onehot(cur_floor);
  assign next_up     = cur_floor + 3'd1;
  assign next_dn     = cur_floor - 3'd1;
  assign up_mask     = onehot(next_up);
  assign dn_mask     = onehot(next_dn);
  assign top_mask    = onehot(TOP);
  assign bottom_mask = onehot(3'd0);

  assign pend_above = any_above(all_req, cur_floor);
  assign pend_below = any_below(all_req, cur_floor);
  assign pend_here  = |(all_req & here_mask);
  assign go_up      = pend_above & ((dir != DIR_DOWN) | !pend_below);

  // Stop test evaluated at the floor the car is about to reach; rev_* marks that
  // the opposite hall call there is served because nothing lies further ahead.
  assign above_next = any_above(all_req, next_up);
  assign below_next = any_below(all_req, next_dn);
  assign rev_up     = (|(queueDown & up_mask)) & !above_next;
  assign rev_dn     = (|(queueUp & dn_mask)) & !below_next;
  assign stop_up    = (|((queueUp | queueinside) & up_mask)) | rev_up | (next_up == TOP);
  assign stop_dn    = (|((queueDown | queueinside) & dn_mask)) | rev_dn | (next_dn == 3'd0);

  // While the door is open, a press already being served here just extends the dwell.
  assign block_up = (state == DOOR_OPEN && dir != DIR_DOWN) ? here_mask : '0;
  assign block_dn = (state == DOOR_OPEN && dir != DIR_UP)   ? here_mask : '0;
  assign block_in = (state == DOOR_OPEN) ? here_mask : '0;
  assign set_up   = outsideUp & ~top_mask & ~block_up;
  assign set_dn   = outsideDown & ~bottom_mask & ~block_dn;
  assign set_in   = insideFloor & ~block_in;
  assign restart  = (|(outsideUp & ~top_mask & block_up)) |
                    (|(outsideDown & ~bottom_mask & block_dn)) |
                    (|(insideFloor & block_in));

  elevator_request_queue #(.FLOORS(FLOORS)) u_queue_up (
    .clk(clk), .rst_n(rst_n), .set_bits(set_up), .clr_bits(clr_up), .q(queueUp)
  );
  elevator_request_queue #(.FLOORS(FLOORS)) u_queue_down (
    .clk(clk), .rst_n(rst_n), .set_bits(set_dn), .clr_bits(clr_dn), .q(queueDown)
  );
  elevator_request_queue #(.FLOORS(FLOORS)) u_queue_inside (
    .clk(clk), .rst_n(rst_n), .set_bits(set_in), .clr_bits(clr_in), .q(queueinside)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_floor <= 3'd0;
      dir       <= DIR_NONE;
      dwell     <= '0;
    end else begin
      state     <= state_next;
      cur_floor <= floor_next;
      dir       <= dir_next;
      dwell     <= dwell_next;
    end
  end

  always_comb begin
    state_next = state;
    floor_next = cur_floor;
    dir_next   = dir;
    dwell_next = dwell;
    clr_up     = '0;
    clr_dn     = '0;
    clr_in     = '0;
    case (state)
      IDLE: if (tick) begin
        if (pend_here) begin
          state_next = DOOR_OPEN;
          dwell_next = '0;
          clr_up     = here_mask;
          clr_dn     = here_mask;
          clr_in     = here_mask;
        end else if (go_up) begin
          state_next = MOVE_UP;
          dir_next   = DIR_UP;
        end else if (pend_below) begin
          state_next = MOVE_DOWN;
          dir_next   = DIR_DOWN;
        end else begin
          dir_next = DIR_NONE;
        end
      end
      MOVE_UP: if (tick) begin
        if (cur_floor >= TOP) begin
          state_next = IDLE;
          dir_next   = DIR_NONE;
        end else begin
          floor_next = next_up;
          if (stop_up) begin
            state_next = DOOR_OPEN;
            dwell_next = '0;
            clr_up     = up_mask;
            clr_in     = up_mask;
            clr_dn     = above_next ? '0 : up_mask;
            dir_next   = rev_up ? DIR_DOWN : DIR_UP;
          end
        end
      end
      MOVE_DOWN: if (tick) begin
        if (cur_floor == 3'd0) begin
          state_next = IDLE;
          dir_next   = DIR_NONE;
        end else begin
          floor_next = next_dn;
          if (stop_dn) begin
            state_next = DOOR_OPEN;
            dwell_next = '0;
            clr_dn     = dn_mask;
            clr_in     = dn_mask;
            clr_up     = below_next ? '0 : dn_mask;
            dir_next   = rev_dn ? DIR_UP : DIR_DOWN;
          end
        end
      end
      DOOR_OPEN: begin
        if (restart) begin
          dwell_next = '0;
        end else if (tick) begin
          if (dwell == DW'(DOOR_TICKS - 1)) begin
            dwell_next = '0;
            if (go_up) begin
              state_next = MOVE_UP;
              dir_next   = DIR_UP;
            end else if (pend_below) begin
              state_next = MOVE_DOWN;
              dir_next   = DIR_DOWN;
            end else begin
              state_next = IDLE;
              dir_next   = DIR_NONE;
            end
          end else begin
            dwell_next = dwell + DW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign currentFloor = cur_floor;
  assign direction    = dir;
  assign doorOpen     = (state == DOOR_OPEN);

endmodule
